// File: rtl/mux_serial_ctrl_pkg.sv
// Shared types and helpers for the 64:1 mux serializer.
package mux_serial_ctrl_pkg;

  localparam int WORD_W  = 64;
  localparam int SEL_W   = 6;
  localparam int MAX_LEN = WORD_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Map an offered length onto 1..MAX_LEN; 0 and anything above MAX_LEN mean a full word.
  function automatic logic [SEL_W:0] clamp_len(input logic [SEL_W:0] len);
    if ((len == '0) || (len > (SEL_W+1)'(MAX_LEN)))
      return (SEL_W+1)'(MAX_LEN);
    else
      return len;
  endfunction

endpackage

// File: rtl/mux_serial_ctrl_mux.sv
// Shared 64:1 bit-select mux.
module Mux_64x1 #(
  parameter int DATA_WIDTH = 64,
  parameter int SEL_WIDTH  = 6
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [SEL_WIDTH-1:0]  i_sel,
  output logic                  o_bit
);

  assign o_bit = i_data[i_sel];

endmodule

// File: rtl/mux_serial_ctrl.sv
// Parallel-to-serial controller around the 64:1 select mux.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | no word held, in_ready high, out_valid low
//   ST_SEND | presenting word_q[sel_q]; advances on each accepted beat
module mux_serial_ctrl
  import mux_serial_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_W,
  parameter int SEL_WIDTH  = SEL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH:0]    in_len,
  input  logic                  in_msb_first,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit,
  output logic                  out_last,
  output logic                  busy,
  output logic [SEL_WIDTH-1:0]  sel_dbg
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_word;
  logic [SEL_WIDTH-1:0]  r_rem;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic                  r_dir;

  logic                  w_mux_bit;
  logic                  w_send;
  logic                  w_last;
  logic                  w_beat;
  logic                  w_accept;
  logic [SEL_WIDTH:0]    w_len_c;
  logic [SEL_WIDTH-1:0]  w_len_m1;

  assign w_send   = (r_state == ST_SEND);
  assign w_last   = w_send && (r_rem == '0);
  assign w_beat   = w_send && out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_len_c  = clamp_len(in_len);
  assign w_len_m1 = SEL_WIDTH'(w_len_c - 1'b1);

  Mux_64x1 #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_mux (
    .i_data (r_word),
    .i_sel  (r_sel),
    .o_bit  (w_mux_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: flush wins; a last beat reloads if a new word arrives on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) w_state_nxt = ST_SEND;
        ST_SEND: if (w_beat && w_last) w_state_nxt = w_accept ? ST_SEND : ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from registers only, except in_ready which follows the sink handshake.
  always_comb begin
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    in_ready  = 1'b0;
    if (w_send) begin
      out_valid = 1'b1;
      out_bit   = w_mux_bit;
      out_last  = w_last;
      busy      = 1'b1;
      in_ready  = out_ready && w_last;
    end else begin
      in_ready  = 1'b1;
    end
    if (flush) in_ready = 1'b0;
  end

  assign sel_dbg = r_sel;

  // Word, remaining count, direction and select: load on acceptance, step on non-last beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_rem  <= '0;
      r_sel  <= '0;
      r_dir  <= 1'b0;
    end else if (w_accept) begin
      r_word <= in_data;
      r_rem  <= w_len_m1;
      r_dir  <= in_msb_first;
      r_sel  <= in_msb_first ? w_len_m1 : '0;
    end else if (w_beat && !w_last) begin
      r_rem  <= r_rem - 1'b1;
      r_sel  <= r_dir ? (r_sel - 1'b1) : (r_sel + 1'b1);
    end
  end

endmodule

// File: tb/tb_mux_serial_ctrl.sv
// Directed bench for mux_serial_ctrl.
module tb_mux_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [6:0]  in_len;
  logic        in_msb_first;
  logic        out_valid;
  logic        out_ready;
  logic        out_bit;
  logic        out_last;
  logic        busy;
  logic [5:0]  sel_dbg;

  int n_checks = 0;
  int n_errors = 0;

  mux_serial_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_len       (in_len),
    .in_msb_first (in_msb_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bit      (out_bit),
    .out_last     (out_last),
    .busy         (busy),
    .sel_dbg      (sel_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic b, input logic l, input logic [5:0] s);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_bit"},   64'(out_bit),   64'(b));
    chk({tag, "_last"},  64'(out_last),  64'(l));
    chk({tag, "_sel"},   64'(sel_dbg),   64'(s));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_ready"}, 64'(in_ready),  64'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk_idle(tag);
    chk({tag, "_last"}, 64'(out_last), 64'd0);
    chk({tag, "_bit"},  64'(out_bit),  64'd0);
    chk({tag, "_sel"},  64'(sel_dbg),  64'd0);
  endtask

  // Present a word in the cycle before the next rising edge; drop it after acceptance
  // and scribble in_data so the bench notices if word_q follows the input.
  task automatic offer(input logic [63:0] d, input logic [6:0] l, input logic m);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_len = l; in_msb_first = m;
    #1 chk("offer_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
  endtask

  logic [63:0] w;
  logic [7:0]  msb_exp;
  int          k;
  int          cyc;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_len = '0; in_msb_first = 1'b0; out_ready = 1'b1;
    #1 chk_reset("rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk_reset("rst_rel");

    // LSB-first, 0xA5, len 8
    w = 64'h0000_0000_0000_00A5;
    offer(w, 7'd8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      chk_beat("lsb", w[i], i == 7, 6'(i));
    end
    @(negedge clk); #1 chk_idle("lsb_done");

    // MSB-first with alternating backpressure
    msb_exp = 8'b1010_0101;
    offer(w, 7'd8, 1'b1);
    k = 0; cyc = 0;
    while (k < 8 && cyc < 40) begin
      @(negedge clk);
      out_ready = (cyc % 2 == 0);
      #1 chk_beat("msb", msb_exp[7-k], k == 7, 6'(7 - k));
      if (out_ready) k++;
      cyc++;
    end
    if (k != 8) chk("msb_timeout", 64'(k), 64'd8);
    out_ready = 1'b1;
    @(negedge clk); #1 chk_idle("msb_done");

    // Back-to-back: 64 ones (len 0 = 64), then 1-bit word on the last beat
    offer(64'hFFFF_FFFF_FFFF_FFFF, 7'd0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 63) begin
        in_valid = 1'b1; in_data = 64'h1; in_len = 7'd1; in_msb_first = 1'b0;
      end
      #1 chk_beat("b2b_a", 1'b1, i == 63, 6'(i));
      if (i == 63) chk("b2b_ready", 64'(in_ready), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk_beat("b2b_b", 1'b1, 1'b1, 6'd0);
    @(negedge clk); #1 chk_idle("b2b_done");

    // Clamp: len 100 acts as 64, MSB-first starts at bit 63
    offer(64'h8000_0000_0000_0000, 7'd100, 1'b1);
    @(negedge clk); #1 chk_beat("clamp", 1'b1, 1'b0, 6'd63);
    @(negedge clk); #1 chk_beat("clamp2", 1'b0, 1'b0, 6'd62);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1 chk_idle("clamp_flush");

    // flush on beat 3 while a word is pending
    w = 64'h0000_0000_0000_000D;
    offer(w, 7'd16, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1 chk_beat("fl", w[i], 1'b0, 6'(i));
    end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = 64'h2; in_len = 7'd2; in_msb_first = 1'b1;
    #1 chk("fl_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_busy", 64'(busy), 64'd0);
    chk("fl_ready2", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk_beat("fl_new0", 1'b1, 1'b0, 6'd1);
    @(negedge clk); #1 chk_beat("fl_new1", 1'b0, 1'b1, 6'd0);
    @(negedge clk); #1 chk_idle("fl_done");

    // Asynchronous reset during beat 5
    w = 64'h0000_0000_0000_003C;
    offer(w, 7'd8, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1 chk_beat("rm", w[i], 1'b0, 6'(i));
    end
    @(negedge clk); #1 chk_beat("rm4", w[4], 1'b0, 6'd4);
    #1 rst_n = 1'b0;
    #1 chk_reset("rm_rst");
    @(negedge clk) rst_n = 1'b1;
    #1 chk_reset("rm_rel");
    w = 64'h0000_0000_0000_0006;
    offer(w, 7'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1 chk_beat("rm_new", w[i], i == 2, 6'(i));
    end
    @(negedge clk); #1 chk_idle("rm_done");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_serial_ctrl.md
# mux_serial_ctrl

Sequencing controller for the 64:1 bit-select mux. It accepts a 64-bit word over a valid/ready handshake and drives the mux select through a programmed number of bit positions, LSB-first or MSB-first. It emits one bit per accepted output beat with backpressure, which turns the combinational mux into a flow-controlled parallel-to-serial port for downstream serial links.

## Interface
- DATA_WIDTH, 64, word width; must equal 2**SEL_WIDTH
- SEL_WIDTH, 6, mux select width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort to IDLE
- in_valid  in  1  word offered
- in_ready  out  1  controller can accept a word this cycle
- in_data  in  DATA_WIDTH  word to serialize
- in_len  in  SEL_WIDTH+1  bits to send; legal 1..64, 0 or >64 treated as 64
- in_msb_first  in  1  1: start at bit len-1 and count down; 0: start at bit 0 and count up
- out_valid  out  1  out_bit valid
- out_ready  in  1  sink accepts bit
- out_bit  out  1  mux output for current select
- out_last  out  1  final bit of the word
- busy  out  1  state != IDLE
- sel_dbg  out  SEL_WIDTH  current mux select, for bench visibility

## Operation
- **States.** IDLE and SEND.
- **Acceptance.** A word is accepted when in_valid && in_ready. On acceptance the controller:
  - latches in_data into word_q;
  - latches the clamped length into rem_q as len-1;
  - latches dir_q;
  - sets sel_q to len-1 (MSB-first) or 0 (LSB-first);
  - moves to SEND.
- **in_ready.** Asserted in IDLE, and in SEND while out_valid && out_ready && out_last.
  - This allows back-to-back words with no bubble.
  - in_ready is forced low while flush=1.
- **SEND outputs.**
  - out_valid = 1.
  - out_bit = mux(word_q, sel_q). This is combinational from registers only; there is no path from input ports.
  - out_last = (rem_q == 0).
- **Beat.** A beat is out_valid && out_ready.
  - Non-last beat: rem_q decrements; sel_q increments (LSB-first) or decrements (MSB-first).
  - Last beat with a new word accepted in the same cycle: reload all registers and stay in SEND.
  - Last beat with no new word: go to IDLE.
- **Holding.** While out_ready=0, out_bit, out_last and sel_q hold stable. A valid beat is never withdrawn.
- **flush.** Has priority over everything else: next state is IDLE, no word is accepted, and registers other than state are don't-care.
- **Word register.** word_q is captured only on acceptance. Changes on in_data during SEND have no effect.

## Timing
- **Reset values.** state=IDLE, in_ready=1, out_valid=0, out_last=0, out_bit=0, busy=0, sel_dbg=0.
  - rst_n is asserted asynchronously at any point, including mid-word. The partial word is discarded and nothing is replayed.
- **Latency.** A word accepted at edge k puts its first bit on out_bit with out_valid=1 in the cycle after edge k.
- **Throughput.** 1 bit/cycle with out_ready held high. A len=N word occupies exactly N cycles of SEND.
- **len=1.** out_last=1 on the first beat.
- **len=64.** sel reaches 63 (LSB-first) or 0 (MSB-first) with no wrap.
  - sel_q never wraps within a word; it uses full-width arithmetic and stops at the end position.
- **Clamp.** in_len=0 behaves identically to in_len=64.

## Structure
- **Shared package.**
  - State enum: IDLE, SEND.
  - Constant MAX_LEN = DATA_WIDTH.
  - Function clamp_len(len) returns the value in 1..64.
- **Sub-module.** One instance of the team's 64-bit select mux, Mux_64x1 (DATA_WIDTH 64, SEL_WIDTH 6), driven by word_q and sel_q.
- **Rest of the block.** FSM, counters and handshake logic live in this module.

## Test plan
- **Reset mid-word.** Accept word, then pulse rst_n low during beat 5 → all outputs at reset values immediately; after release in_ready=1 and the next word starts from its own first bit.
- **LSB-first.** in_data=64'h0000_0000_0000_00A5, len=8, LSB-first, out_ready=1 → bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles; out_last only on the 8th; first bit one cycle after acceptance.
- **MSB-first with backpressure.** Same data, len=8, MSB-first, out_ready toggling 1,0,1,0 → 1,0,1,0,0,1,0,1 delivered; out_bit, out_last and sel_dbg stable during each stalled cycle.
- **Back-to-back.**
  - Word A = 64'hFFFF_FFFF_FFFF_FFFF, len=0.
  - Word B = 64'h1, len=1, presented on A's last beat.
  - Required response:
    - A sends 64 ones with sel_dbg 0..63.
    - B is accepted on that same edge.
    - B's bit 1 with out_last=1 follows with no idle cycle.
- **flush.** Word len=16; assert flush on beat 3 while in_valid=1 → in_ready=0 that cycle; next cycle out_valid=0, busy=0; the pending word is accepted no earlier than the cycle after flush drops.
